lfsr_bert_controller: RTL and testbench
=======================================

# lfsr_bert_controller

Bit-error-rate test sequencer that sits downstream of a PRBS/LFSR stream (for example a link receiving the output of the LFSR generator). It acquires lock on the incoming 32-bit stream and then free-runs its own reference LFSR. Each received word is compared with the reference, and the block counts words, errored words, errored bits and lock losses. A start/stop interface runs a fixed-length or open-ended test, and the counters are held for readout when the test ends.

## Interface
Parameters:
- `POLY`, `32'h80000057`: feedback tap mask; new bit = XOR-reduce(state & `POLY`).
- `ITERATIONS`, `1`: LFSR shifts per word. Shift rule: state = {state[30:0], new bit}.
- `LOCK_COUNT`, `16`: consecutive matching words needed to declare lock (≥1).
- `UNLOCK_COUNT`, `4`: consecutive mismatching words, while locked, that cause loss of lock (≥1).
- `CNT_WIDTH`, `32`: width of the word, error and bit-error counters.

Ports:
- `clk`, in, 1: the only clock.
- `aresetn`, in, 1: reset, synchronous, active-low.
- `S_AXIS_TDATA`, in, 32: received PRBS word.
- `S_AXIS_TVALID`, in, 1: beat qualifier.
- `S_AXIS_TREADY`, out, 1: constant 1.
- `start`, in, 1: single-cycle pulse; clears counters and begins acquisition.
- `stop`, in, 1: single-cycle pulse; ends the test.
- `test_words`, in, CNT_WIDTH: number of locked words per test; 0 means run until `stop`. Sampled on `start`.
- `running`, out, 1: state is ACQUIRE or LOCKED.
- `locked`, out, 1: state is LOCKED.
- `done`, out, 1: state is DONE.
- `word_count`, out, CNT_WIDTH: beats compared while LOCKED.
- `error_count`, out, CNT_WIDTH: LOCKED beats with any mismatch.
- `bit_error_count`, out, CNT_WIDTH: total mismatched bits, i.e. popcount(data ^ expected), in LOCKED.
- `lock_loss_count`, out, 16: number of LOCKED→ACQUIRE transitions.

## Operation
- **Beat definition.** A beat is a cycle with `S_AXIS_TVALID`=1 in state ACQUIRE or LOCKED. Cycles without a beat change no state or counter.
- **Expected word.** `expected` = adv(`ref`), where adv applies the shift rule `ITERATIONS` times. `ref_valid` marks `ref` as usable.
- **States:** IDLE, ACQUIRE, LOCKED, DONE.
- **IDLE.** Waits for `start`.
- **ACQUIRE (self-synchronising).**
  - Every beat loads `ref` with the received word.
  - The first beat after entry only sets `ref_valid`; no comparison is made.
  - Later beats compare the data with `expected`. A match increments `good_run`; a mismatch clears `good_run` to 0.
  - When `good_run` reaches `LOCK_COUNT`, go to LOCKED and clear `bad_run`.
- **LOCKED (free-running).**
  - Every beat loads `ref` with `expected`, not with the received data, so one flipped bit counts as exactly one errored word.
  - Every beat increments `word_count`.
  - On a mismatch: increment `error_count`, add popcount to `bit_error_count`, increment `bad_run`.
  - On a match: clear `bad_run` to 0.
  - When `bad_run` reaches `UNLOCK_COUNT`: increment `lock_loss_count`, go to ACQUIRE, clear `ref_valid` and `good_run`.
  - When `test_words`≠0 and the incremented `word_count` equals `test_words`: go to DONE. This takes priority over the unlock transition in the same beat.
- **DONE.** Counters hold their values until the next `start`.
- **`start`** in any state:
  - zeroes all counters, `good_run`, `bad_run` and `ref_valid`;
  - latches `test_words`;
  - goes to ACQUIRE.
- **`stop`** in ACQUIRE or LOCKED goes to DONE. In IDLE or DONE it is ignored.
- **Simultaneous `start` and `stop`:** `start` wins.
- **A beat in the same cycle as `start` or `stop`** is discarded.
- **Counter widths.** All counters saturate at their maximum. `bit_error_count` saturates on the addition.

## Timing
- **Reset values:** state IDLE; `running`, `locked` and `done` are 0; all counters are 0; `ref` = 0; `ref_valid` = 0; `S_AXIS_TREADY` = 1.
- **Registered outputs.** All outputs are registered. A beat in cycle n is reflected in the counters and status outputs at cycle n+1.
- **`start` / `stop` latency.** `start` in cycle n gives `running`=1 at n+1. `stop` in cycle n gives `done`=1 at n+1.
- **Minimum time to lock** is `LOCK_COUNT`+1 beats from entering ACQUIRE. `locked` rises the cycle after the last of these beats.
- **Reset mid-test.** Reset at any time returns the block to the reset values on the next edge. No partial counts are preserved.

## Test plan
1. **Clean run.** Clean PRBS stream from `POLY`/`ITERATIONS`, `start` with `test_words`=100, continuous valid. Required: `locked` rises after the 17th beat; `done` rises after 100 locked beats; `word_count`=100, `error_count`=0, `bit_error_count`=0, `lock_loss_count`=0.
2. **Single-bit errors.** Same stream with bit 5 flipped in locked word 10 and bits 0/31 flipped in word 20. Required: `error_count`=2, `bit_error_count`=3, no lock loss, `word_count`=100.
3. **Loss of lock.** Four consecutive words of `32'h00000000` injected while LOCKED. Required: `lock_loss_count`=1, `locked` drops, and it reasserts 17 clean beats later. `error_count` includes the 4 bad words; `word_count` excludes ACQUIRE beats.
4. **TVALID gaps.** `S_AXIS_TVALID` toggled on alternate cycles during a `test_words`=50 run. Required: results identical to scenario 1 scaled to 50 words (`word_count`=50, `error_count`=0), and the test takes about twice as many cycles.
5. **Control corner cases.** Open-ended run (`test_words`=0):
   - `stop` after 30 locked beats → `done`=1, `word_count`=30, and the counters hold while the stream continues;
   - simultaneous `start`+`stop` → counters zeroed and state ACQUIRE.
6. **Reset mid-test.** `aresetn`=0 for one cycle while LOCKED. Required: all outputs return to their reset values on the next cycle, and beats are ignored until `start`.

Source files
------------

// File: rtl/lfsr_bert_controller.sv
// BER test sequencer: self-synchronises a reference LFSR to a received PRBS stream,
// then free-runs it and counts words, errored words, errored bits and lock losses.
module lfsr_bert_controller #(
    parameter logic [31:0] POLY         = 32'h80000057,
    parameter int          ITERATIONS   = 1,
    parameter int          LOCK_COUNT   = 16,
    parameter int          UNLOCK_COUNT = 4,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [31:0]          S_AXIS_TDATA,
    input  logic                 S_AXIS_TVALID,
    output logic                 S_AXIS_TREADY,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] test_words,
    output logic                 running,
    output logic                 locked,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic [CNT_WIDTH-1:0] bit_error_count,
    output logic [15:0]          lock_loss_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [31:0]            r_ref, w_ref_next;
    logic                   r_ref_valid, w_ref_valid_next;
    logic [31:0]            r_good_run, w_good_run_next;
    logic [31:0]            r_bad_run, w_bad_run_next;
    logic [CNT_WIDTH-1:0]   r_test_words, w_test_words_next;
    logic [CNT_WIDTH-1:0]   r_word_count, w_word_count_next;
    logic [CNT_WIDTH-1:0]   r_error_count, w_error_count_next;
    logic [CNT_WIDTH-1:0]   r_bit_error_count, w_bit_error_count_next;
    logic [15:0]            r_lock_loss_count, w_lock_loss_count_next;
    logic                   r_running, r_locked, r_done;

    logic [31:0]            w_expected;
    logic [31:0]            w_diff;
    logic [5:0]             w_popcount;
    logic                   w_mismatch;
    logic                   w_beat;
    logic [31:0]            w_good_inc;
    logic [31:0]            w_bad_inc;
    logic [CNT_WIDTH-1:0]   w_word_inc;
    logic [CNT_WIDTH-1:0]   w_error_inc;
    logic [CNT_WIDTH:0]     w_bit_sum;
    logic [CNT_WIDTH-1:0]   w_bit_sat;
    logic [15:0]            w_lock_loss_inc;

    assign S_AXIS_TREADY = 1'b1;

    always_comb begin
        w_expected = r_ref;
        for (int i = 0; i < ITERATIONS; i++) begin
            w_expected = {w_expected[30:0], ^(w_expected & POLY)};
        end
    end

    assign w_diff     = S_AXIS_TDATA ^ w_expected;
    assign w_mismatch = |w_diff;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < 32; i++) begin
            w_popcount = w_popcount + {5'd0, w_diff[i]};
        end
    end

    // All counters saturate rather than wrap
    assign w_good_inc      = r_good_run + 32'd1;
    assign w_bad_inc       = r_bad_run + 32'd1;
    assign w_word_inc      = (&r_word_count) ? r_word_count : r_word_count + CNT_WIDTH'(1);
    assign w_error_inc     = (&r_error_count) ? r_error_count : r_error_count + CNT_WIDTH'(1);
    assign w_bit_sum       = {1'b0, r_bit_error_count} + (CNT_WIDTH + 1)'(w_popcount);
    assign w_bit_sat       = w_bit_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_bit_sum[CNT_WIDTH-1:0];
    assign w_lock_loss_inc = (&r_lock_loss_count) ? r_lock_loss_count : r_lock_loss_count + 16'd1;

    // Beats coinciding with a start or stop pulse are discarded
    assign w_beat = S_AXIS_TVALID && !start && !stop &&
                    (r_state == ST_ACQUIRE || r_state == ST_LOCKED);

    always_comb begin
        w_state_next           = r_state;
        w_ref_next             = r_ref;
        w_ref_valid_next       = r_ref_valid;
        w_good_run_next        = r_good_run;
        w_bad_run_next         = r_bad_run;
        w_test_words_next      = r_test_words;
        w_word_count_next      = r_word_count;
        w_error_count_next     = r_error_count;
        w_bit_error_count_next = r_bit_error_count;
        w_lock_loss_count_next = r_lock_loss_count;

        if (start) begin
            w_state_next           = ST_ACQUIRE;
            w_ref_valid_next       = 1'b0;
            w_good_run_next        = '0;
            w_bad_run_next         = '0;
            w_test_words_next      = test_words;
            w_word_count_next      = '0;
            w_error_count_next     = '0;
            w_bit_error_count_next = '0;
            w_lock_loss_count_next = '0;
        end else if (stop && (r_state == ST_ACQUIRE || r_state == ST_LOCKED)) begin
            w_state_next = ST_DONE;
        end else if (w_beat) begin
            if (r_state == ST_ACQUIRE) begin
                w_ref_next = S_AXIS_TDATA;
                if (!r_ref_valid) begin
                    w_ref_valid_next = 1'b1;
                end else if (!w_mismatch) begin
                    w_good_run_next = w_good_inc;
                    if (w_good_inc == 32'(LOCK_COUNT)) begin
                        w_state_next   = ST_LOCKED;
                        w_bad_run_next = '0;
                    end
                end else begin
                    w_good_run_next = '0;
                end
            end else begin
                // Free-run the reference so an errored word cannot corrupt later comparisons
                w_ref_next        = w_expected;
                w_word_count_next = w_word_inc;
                if (w_mismatch) begin
                    w_error_count_next     = w_error_inc;
                    w_bit_error_count_next = w_bit_sat;
                    w_bad_run_next         = w_bad_inc;
                end else begin
                    w_bad_run_next = '0;
                end
                if (r_test_words != '0 && w_word_inc == r_test_words) begin
                    w_state_next = ST_DONE;
                end else if (w_mismatch && w_bad_inc == 32'(UNLOCK_COUNT)) begin
                    w_state_next           = ST_ACQUIRE;
                    w_lock_loss_count_next = w_lock_loss_inc;
                    w_ref_valid_next       = 1'b0;
                    w_good_run_next        = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state           <= ST_IDLE;
            r_ref             <= '0;
            r_ref_valid       <= 1'b0;
            r_good_run        <= '0;
            r_bad_run         <= '0;
            r_test_words      <= '0;
            r_word_count      <= '0;
            r_error_count     <= '0;
            r_bit_error_count <= '0;
            r_lock_loss_count <= '0;
            r_running         <= 1'b0;
            r_locked          <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_ref             <= w_ref_next;
            r_ref_valid       <= w_ref_valid_next;
            r_good_run        <= w_good_run_next;
            r_bad_run         <= w_bad_run_next;
            r_test_words      <= w_test_words_next;
            r_word_count      <= w_word_count_next;
            r_error_count     <= w_error_count_next;
            r_bit_error_count <= w_bit_error_count_next;
            r_lock_loss_count <= w_lock_loss_count_next;
            r_running         <= (w_state_next == ST_ACQUIRE) || (w_state_next == ST_LOCKED);
            r_locked          <= (w_state_next == ST_LOCKED);
            r_done            <= (w_state_next == ST_DONE);
        end
    end

    assign running         = r_running;
    assign locked          = r_locked;
    assign done            = r_done;
    assign word_count      = r_word_count;
    assign error_count     = r_error_count;
    assign bit_error_count = r_bit_error_count;
    assign lock_loss_count = r_lock_loss_count;

endmodule

// File: tb/tb_lfsr_bert_controller.sv
// Directed bench for lfsr_bert_controller: clean run, bit errors, lock loss,
// TVALID gaps, start/stop corner cases and mid-test reset.
module tb_lfsr_bert_controller;

    logic        clk;
    logic        aresetn;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        start;
    logic        stop;
    logic [31:0] test_words;
    logic        running;
    logic        locked;
    logic        done;
    logic [31:0] wc;
    logic [31:0] ec;
    logic [31:0] bec;
    logic [15:0] llc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] w;
    logic [31:0] wp;

    lfsr_bert_controller dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .S_AXIS_TDATA    (tdata),
        .S_AXIS_TVALID   (tvalid),
        .S_AXIS_TREADY   (tready),
        .start           (start),
        .stop            (stop),
        .test_words      (test_words),
        .running         (running),
        .locked          (locked),
        .done            (done),
        .word_count      (wc),
        .error_count     (ec),
        .bit_error_count (bec),
        .lock_loss_count (llc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] prbs_next(input logic [31:0] x);
        return {x[30:0], ^(x & 32'h80000057)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        tdata  = d;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
    endtask

    task automatic clean();
        beat(w);
        wp = w;
        w  = prbs_next(w);
    endtask

    task automatic do_start(input logic [31:0] tw);
        test_words = tw;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic acquire(input string tag);
        for (int i = 0; i < 16; i++) clean();
        chk({tag, "_locked_after16"}, locked, 1'b0);
        clean();
        chk({tag, "_locked_after17"}, locked, 1'b1);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        logic [31:0] d;

        aresetn = 1'b0; tdata = '0; tvalid = 1'b0; start = 1'b0; stop = 1'b0;
        test_words = '0;
        w = 32'h1; wp = 32'h0;
        tick(); tick();
        chk("rst_running", running, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wc", wc, 32'd0);
        chk("rst_llc", llc, 16'd0);
        chk("rst_tready", tready, 1'b1);
        aresetn = 1'b1;
        tick();

        // stop while idle is ignored
        stop = 1'b1; tick(); stop = 1'b0;
        chk("idle_stop_done", done, 1'b0);

        // Scenario 1: clean run of 100 words
        do_start(32'd100);
        chk("s1_running", running, 1'b1);
        chk("s1_locked0", locked, 1'b0);
        acquire("s1");
        for (int k = 1; k <= 100; k++) begin
            clean();
            if (k == 99) chk("s1_done_at99", done, 1'b0);
        end
        chk("s1_done", done, 1'b1);
        chk("s1_running_end", running, 1'b0);
        chk("s1_wc", wc, 32'd100);
        chk("s1_ec", ec, 32'd0);
        chk("s1_bec", bec, 32'd0);
        chk("s1_llc", llc, 16'd0);

        // Scenario 2: bit errors in locked words 10 and 20
        do_start(32'd100);
        chk("s2_wc_cleared", wc, 32'd0);
        acquire("s2");
        for (int k = 1; k <= 100; k++) begin
            d = w;
            if (k == 10) d = d ^ 32'h00000020;
            if (k == 20) d = d ^ 32'h80000001;
            beat(d);
            wp = w;
            w  = prbs_next(w);
        end
        chk("s2_done", done, 1'b1);
        chk("s2_wc", wc, 32'd100);
        chk("s2_ec", ec, 32'd2);
        chk("s2_bec", bec, 32'd3);
        chk("s2_llc", llc, 16'd0);

        // Scenario 3: loss of lock from four zero words
        do_start(32'd0);
        acquire("s3");
        for (int k = 0; k < 10; k++) clean();
        for (int k = 1; k <= 4; k++) begin
            beat(32'h0);
            wp = w;
            w  = prbs_next(w);
            if (k == 3) chk("s3_locked_after3bad", locked, 1'b1);
        end
        chk("s3_locked_dropped", locked, 1'b0);
        chk("s3_running", running, 1'b1);
        chk("s3_llc", llc, 16'd1);
        chk("s3_ec", ec, 32'd4);
        chk("s3_wc", wc, 32'd14);
        acquire("s3_relock");
        chk("s3_wc_after_relock", wc, 32'd14);
        clean();
        chk("s3_wc_plus1", wc, 32'd15);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("s3_stop_done", done, 1'b1);
        chk("s3_final_ec", ec, 32'd4);

        // Scenario 4: TVALID on alternate cycles, 50 words
        do_start(32'd50);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 400 && !seen; c++) begin
            if ((c % 2) == 1) begin
                clean();
            end else begin
                tdata  = 32'hDEADBEEF;
                tvalid = 1'b0;
                tick();
            end
            if (done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        chk("s4_done_seen", seen, 1'b1);
        chk("s4_cycles", cyc, 133);
        chk("s4_wc", wc, 32'd50);
        chk("s4_ec", ec, 32'd0);
        chk("s4_llc", llc, 16'd0);

        // Scenario 5: open-ended run; beats in start/stop cycles are discarded
        tdata = wp; tvalid = 1'b1;
        do_start(32'd0);
        tvalid = 1'b0;
        acquire("s5");
        for (int k = 0; k < 30; k++) clean();
        tdata = w; tvalid = 1'b1; stop = 1'b1;
        tick();
        tvalid = 1'b0; stop = 1'b0;
        chk("s5_done", done, 1'b1);
        chk("s5_running", running, 1'b0);
        chk("s5_wc", wc, 32'd30);
        for (int k = 0; k < 5; k++) clean();
        chk("s5_wc_hold", wc, 32'd30);
        chk("s5_done_hold", done, 1'b1);
        tdata = w; tvalid = 1'b1; start = 1'b1; stop = 1'b1; test_words = 32'd0;
        tick();
        tvalid = 1'b0; start = 1'b0; stop = 1'b0;
        chk("s5_ss_running", running, 1'b1);
        chk("s5_ss_done", done, 1'b0);
        chk("s5_ss_locked", locked, 1'b0);
        chk("s5_ss_wc", wc, 32'd0);
        acquire("s5_ss");

        // Scenario 6: reset while locked
        for (int k = 0; k < 5; k++) clean();
        chk("s6_wc_pre", wc, 32'd5);
        aresetn = 1'b0;
        clean();
        aresetn = 1'b1;
        chk("s6_running", running, 1'b0);
        chk("s6_locked", locked, 1'b0);
        chk("s6_done", done, 1'b0);
        chk("s6_wc", wc, 32'd0);
        chk("s6_tready", tready, 1'b1);
        for (int k = 0; k < 20; k++) clean();
        chk("s6_idle_running", running, 1'b0);
        chk("s6_idle_wc", wc, 32'd0);
        chk("s6_idle_locked", locked, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
